// File: rtl/fp_mul_norm_round_pipe.sv
// Normalise/round back end for the FP multiplier: 2-stage valid/ready pipe.
// FP_MUL_RNE_EN selects round-to-nearest-even; otherwise legacy round-half-up.
module fp_mul_norm_round_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int AUX_W = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*MAN_W+1:0]     prod_in,
  input  logic [EXP_W+1:0]       exp_in,
  input  logic [AUX_W-1:0]       aux_in,
  input  logic                   err_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] float_out,
  output logic [AUX_W-1:0]       aux_out,
  output logic                   ovf_out,
  output logic                   unf_out,
  output logic                   err_out
);

  localparam int PW   = 2*MAN_W+2;
  localparam int EW   = EXP_W+2;
  localparam int BIAS = (1 << (EXP_W-1)) - 1;
  localparam int FW   = EXP_W+MAN_W;

  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E = '0;

  // Stage-1 state
  logic                   s1_valid_q, s1_valid_d;
  logic [MAN_W-1:0]       s1_mant_q, s1_mant_d;
  logic                   s1_guard_q, s1_guard_d;
  logic signed [EW-1:0]   s1_e_q, s1_e_d;
  logic [AUX_W-1:0]       s1_aux_q, s1_aux_d;
  logic                   s1_err_q, s1_err_d;

  // Output register state
  logic                   out_valid_q, out_valid_d;
  logic [FW-1:0]          float_q, float_d;
  logic [AUX_W-1:0]       aux_q, aux_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   err_q, err_d;

  // Normaliser combinational results
  logic [MAN_W-1:0]       n_mant;
  logic                   n_guard;
  logic signed [EW-1:0]   n_e;

  // Rounder / classifier combinational results
  logic                   inc;
  logic                   carry;
  logic [MAN_W-1:0]       r_mant;
  logic signed [EW-1:0]   r_e;
  logic [FW-1:0]          r_float;
  logic                   r_ovf, r_unf, r_err;

  logic                   s1_en, s2_en;

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  assign out_valid = out_valid_q;
  assign float_out = float_q;
  assign aux_out   = aux_q;
  assign ovf_out   = ovf_q;
  assign unf_out   = unf_q;
  assign err_out   = err_q;

  // Align the product so the leading one is implicit; pick guard bit
  always_comb begin
    if (prod_in[PW-1]) begin
      n_mant  = prod_in[PW-2 -: MAN_W];
      n_guard = prod_in[PW-2-MAN_W];
      n_e     = $signed(exp_in) + BIAS_E + ONE_E;
    end else begin
      n_mant  = prod_in[PW-3 -: MAN_W];
      n_guard = prod_in[PW-3-MAN_W];
      n_e     = $signed(exp_in) + BIAS_E;
    end
  end

`ifdef FP_MUL_RNE_EN
  logic s1_sticky_q, s1_sticky_d;
  logic n_sticky;

  // Sticky is the OR of every bit below the guard position
  always_comb begin
    n_sticky    = prod_in[PW-1] ? |prod_in[PW-3-MAN_W:0]
                                : |prod_in[PW-4-MAN_W:0];
    s1_sticky_d = s1_sticky_q;
    if (s1_en && in_valid) s1_sticky_d = n_sticky;
  end

  // Sticky flop rides with the rest of stage 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_sticky_q <= 1'b0;
    else     s1_sticky_q <= s1_sticky_d;
  end

  assign inc = s1_guard_q & (s1_sticky_q | s1_mant_q[0]);
`else
  logic unused_lsbs;

  assign unused_lsbs = ^prod_in[PW-4-MAN_W:0];
  assign inc         = s1_guard_q;
`endif

  // Round, renormalise on carry-out and classify the result
  always_comb begin
    {carry, r_mant} = {1'b0, s1_mant_q} + {{MAN_W{1'b0}}, inc};
    r_e     = s1_e_q + (carry ? ONE_E : ZERO_E);
    r_float = {r_e[EXP_W-1:0], r_mant};
    r_ovf   = 1'b0;
    r_unf   = 1'b0;
    r_err   = 1'b0;
    if (s1_err_q) begin
      r_float = '1;
      r_err   = 1'b1;
    end else if (r_e >= EMAX_E) begin
      r_float = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r_ovf   = 1'b1;
    end else if (r_e <= ZERO_E) begin
      r_float = '0;
      r_unf   = 1'b1;
    end
  end

  // Next-state for both stages; data moves only on its stage enable
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mant_d   = s1_mant_q;
    s1_guard_d  = s1_guard_q;
    s1_e_d      = s1_e_q;
    s1_aux_d    = s1_aux_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    float_d     = float_q;
    aux_d       = aux_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    err_d       = err_q;
    if (s1_en) s1_valid_d = in_valid;
    if (s1_en && in_valid) begin
      s1_mant_d  = n_mant;
      s1_guard_d = n_guard;
      s1_e_d     = n_e;
      s1_aux_d   = aux_in;
      s1_err_d   = err_in;
    end
    if (s2_en) out_valid_d = s1_valid_q;
    if (s2_en && s1_valid_q) begin
      float_d = r_float;
      aux_d   = s1_aux_q;
      ovf_d   = r_ovf;
      unf_d   = r_unf;
      err_d   = r_err;
    end
  end

  // Pipeline registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mant_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_e_q      <= '0;
      s1_aux_q    <= '0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      float_q     <= '0;
      aux_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mant_q   <= s1_mant_d;
      s1_guard_q  <= s1_guard_d;
      s1_e_q      <= s1_e_d;
      s1_aux_q    <= s1_aux_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      float_q     <= float_d;
      aux_q       <= aux_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      err_q       <= err_d;
    end
  end

endmodule
